// File: rtl/scan_test_ctrl.sv
// Scan-chain test sequencer: shifts a state vector into a mux-D scan chain,
// runs one functional capture cycle, then shifts the captured state back out.
module scan_test_ctrl #(
  parameter int CHAIN_LEN = 3,
  parameter int NPI       = 4,
  parameter int NPO       = 1,
  parameter int CNT_W     = 2
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [NPI-1:0]       pi_in,
  output logic                 busy,
  output logic                 done,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic [NPI-1:0]       pi_out,
  input  logic                 scan_out,
  input  logic [NPO-1:0]       po_in,
  output logic [CHAIN_LEN-1:0] resp_state,
  output logic [NPO-1:0]       resp_po
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [CHAIN_LEN-1:0] load_sr_reg, load_sr_next;
  logic [NPI-1:0]       pi_reg, pi_next;
  logic [CHAIN_LEN-1:0] resp_state_reg, resp_state_next;
  logic [NPO-1:0]       resp_po_reg, resp_po_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 scan_en_reg, scan_en_next;
  logic                 scan_in_reg, scan_in_next;
  logic [NPI-1:0]       pi_out_reg, pi_out_next;
  logic [CHAIN_LEN-1:0] unload_shift;
  logic                 last_cnt;

  assign last_cnt = (cnt_reg == CNT_W'(CHAIN_LEN - 1));

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    load_sr_next    = load_sr_reg;
    pi_next         = pi_reg;
    resp_state_next = resp_state_reg;
    resp_po_next    = resp_po_reg;
    // First bit unloaded ends up in the MSB after CHAIN_LEN shifts.
    unload_shift    = resp_state_reg << 1;
    unload_shift[0] = scan_out;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = LOAD;
          cnt_next     = '0;
          load_sr_next = pattern_in;
          pi_next      = pi_in;
        end
      end
      LOAD: begin
        load_sr_next = load_sr_reg << 1;
        if (last_cnt) begin
          state_next = CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      CAPTURE: begin
        resp_po_next = po_in;
        state_next   = UNLOAD;
        cnt_next     = '0;
      end
      UNLOAD: begin
        resp_state_next = unload_shift;
        if (last_cnt) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Outputs are decoded from the upcoming state so they register in step with it.
    busy_next    = (state_next != IDLE);
    done_next    = (state_next == DONE);
    scan_en_next = (state_next == LOAD) || (state_next == UNLOAD);
    scan_in_next = (state_next == LOAD) ? load_sr_next[CHAIN_LEN-1] : 1'b0;
    pi_out_next  = (state_next == CAPTURE) ? pi_reg : '0;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      load_sr_reg    <= '0;
      pi_reg         <= '0;
      resp_state_reg <= '0;
      resp_po_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      scan_en_reg    <= 1'b0;
      scan_in_reg    <= 1'b0;
      pi_out_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      load_sr_reg    <= load_sr_next;
      pi_reg         <= pi_next;
      resp_state_reg <= resp_state_next;
      resp_po_reg    <= resp_po_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      scan_en_reg    <= scan_en_next;
      scan_in_reg    <= scan_in_next;
      pi_out_reg     <= pi_out_next;
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign scan_en    = scan_en_reg;
  assign scan_in    = scan_in_reg;
  assign pi_out     = pi_out_reg;
  assign resp_state = resp_state_reg;
  assign resp_po    = resp_po_reg;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Directed bench for scan_test_ctrl driving an s27-style scanned core model
// (or a bare shift-register stub when s27_mode is 0).
module tb_scan_test_ctrl;

  logic       CK = 1'b0;
  logic       RST;
  logic       start;
  logic [2:0] pattern_in;
  logic [3:0] pi_in;
  logic       busy, done, scan_en, scan_in, scan_out;
  logic [3:0] pi_out;
  logic [0:0] po_in;
  logic [2:0] resp_state;
  logic [0:0] resp_po;

  int passed = 0;
  int total  = 0;

  always #5 CK = ~CK;

  scan_test_ctrl #(.CHAIN_LEN(3), .NPI(4), .NPO(1), .CNT_W(2)) dut (
    .CK(CK), .RST(RST), .start(start), .pattern_in(pattern_in), .pi_in(pi_in),
    .busy(busy), .done(done), .scan_en(scan_en), .scan_in(scan_in), .pi_out(pi_out),
    .scan_out(scan_out), .po_in(po_in), .resp_state(resp_state), .resp_po(resp_po)
  );

  // Scanned core: q[0]=G5 (nearest scan_in), q[1]=G6, q[2]=G7.
  logic [2:0] q = 3'b000;
  logic       s27_mode = 1'b1;
  logic g0, g1, g2, g3, g8, g9, g10, g11, g12, g13, g14, g15, g16, g17;
  always_comb begin
    {g3, g2, g1, g0} = pi_out;
    g14 = ~g0;
    g8  = g14 & q[1];
    g12 = ~(g1 | q[2]);
    g15 = g12 | g8;
    g16 = g3 | g8;
    g9  = ~(g16 & g15);
    g11 = ~(q[0] | g9);
    g10 = ~(g14 | g11);
    g13 = ~(g2 | g12);
    g17 = ~g11;
  end
  assign scan_out = q[2];
  assign po_in    = g17;

  always @(posedge CK) begin
    if (scan_en) q <= {q[1:0], scan_in};
    else if (s27_mode) q <= {g13, g11, g10};
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One full pattern; the expected scan_in and scan_out sequences are given
  // first-bit-first as 3-bit vectors (bit 2 appears first).
  task automatic run_pat(input string name, input logic [2:0] pat, input logic [3:0] pi,
                         input logic [2:0] exp_sin, input logic [2:0] exp_sout,
                         input logic [2:0] exp_resp, input logic exp_po,
                         input logic pulse_in_unload);
    int ndone;
    pattern_in = pat;
    pi_in      = pi;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    pattern_in = ~pat;
    pi_in      = ~pi;
    for (int k = 0; k < 3; k++) begin
      chk({name, "_load_scan_en"}, scan_en, 1);
      chk({name, "_load_scan_in"}, scan_in, exp_sin[2-k]);
      tick();
    end
    chk({name, "_cap_scan_en"}, scan_en, 0);
    chk({name, "_cap_pi_out"}, pi_out, pi);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk({name, "_unl_scan_en"}, scan_en, 1);
      chk({name, "_unl_scan_out"}, scan_out, exp_sout[2-k]);
      chk({name, "_unl_pi_out"}, pi_out, 0);
      if (pulse_in_unload && k == 1) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_done_busy"}, busy, 1);
    chk({name, "_done_scan_en"}, scan_en, 0);
    chk({name, "_resp_state"}, resp_state, exp_resp);
    chk({name, "_resp_po"}, resp_po, exp_po);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) ndone++;
    end
    chk({name, "_no_extra_done"}, ndone, 0);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_resp_state_hold"}, resp_state, exp_resp);
    chk({name, "_resp_po_hold"}, resp_po, exp_po);
    $display("pattern %s pat=%b pi=%b resp_state=%b resp_po=%b", name, pat, pi, resp_state, resp_po);
  endtask

  initial begin
    int ndone, first_done, second_done, busy_low;
    RST = 1'b1; start = 1'b0; pattern_in = '0; pi_in = '0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_scan_en", scan_en, 0);
    chk("rst_scan_in", scan_in, 0);
    chk("rst_pi_out", pi_out, 0);
    chk("rst_resp", {resp_state, resp_po}, 0);
    $display("reset released: busy=%b done=%b scan_en=%b", busy, done, scan_en);

    // Reset asserted for two cycles in the middle of LOAD.
    pattern_in = 3'b111; pi_in = 4'hf; start = 1'b1;
    tick();
    start = 1'b0;
    chk("midrst_in_load", scan_en, 1);
    tick();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    chk("midrst_scan_en", scan_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_resp", {resp_state, resp_po}, 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    $display("mid-LOAD reset: busy=%b done=%b scan_en=%b", busy, done, scan_en);

    s27_mode = 1'b1;
    run_pat("s27_101", 3'b101, 4'b0000, 3'b101, 3'b100, 3'b100, 1'b1, 1'b0);
    run_pat("s27_000", 3'b000, 4'b0001, 3'b000, 3'b001, 3'b001, 1'b1, 1'b0);

    s27_mode = 1'b0;
    run_pat("stub_110", 3'b110, 4'b1010, 3'b110, 3'b110, 3'b110, 1'b0, 1'b0);
    run_pat("stub_011_pulse", 3'b011, 4'b0000, 3'b011, 3'b011, 3'b011, 1'b1, 1'b1);

    // start held high: second acceptance only after DONE, one idle cycle between.
    pattern_in = 3'b101; pi_in = 4'b0000; start = 1'b1;
    tick();
    ndone = 0; first_done = 0; second_done = 0; busy_low = 0;
    for (int i = 2; i <= 17; i++) begin
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) first_done = i;
        else second_done = i;
      end else if (!busy && ndone == 1) begin
        busy_low++;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", ndone, 2);
    chk("b2b_first_done", first_done, 8);
    chk("b2b_second_done", second_done, 17);
    chk("b2b_busy_low", busy_low, 1);
    chk("b2b_resp_state", resp_state, 3'b101);
    tick(); tick();
    chk("b2b_idle_busy", busy, 0);
    $display("back-to-back: dones at %0d and %0d, busy low %0d cycle(s)", first_done, second_done, busy_low);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
